// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush, optional skid buffer and stall counter
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   reset_i      asynchronous active-low reset
//   in_valid_i   upstream holds a valid item
//   in_ready_o   stage can accept this cycle
//   in_data_i    upstream payload (DATA_W)
//   in_ctrl_i    upstream control field (CTRL_W)
//   flush_i      synchronous kill of all held and incoming items
//   out_valid_o  stage presents a valid item
//   out_ready_i  downstream accepts this cycle
//   out_data_o   held payload (keeps last value when invalid)
//   out_ctrl_o   held control field, zero when out_valid_o is low
//   occupancy_o  number of items held (0..2)
//   stall_cnt_o  saturating count of back-pressured cycles
//   clr_stats_i  synchronous clear of stall_cnt_o

module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o,
    output logic [15:0]       stall_cnt_o,
    input  logic              clr_stats_i
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    logic              out_valid;
    logic [DATA_W-1:0] held_data;
    logic [CTRL_W-1:0] held_ctrl;
    logic [1:0]        occ;
    logic              push;
    logic              pop;
    logic [15:0]       stall_cnt_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid & out_ready_i;

    generate
        if (SKID == 0) begin : g_single
            logic              rst_done_q;
            logic              valid_q;
            logic [DATA_W-1:0] data_q;
            logic [CTRL_W-1:0] ctrl_q;

            // Holds in_ready_o low until the first edge after reset release.
            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    rst_done_q <= 1'b0;
                end else begin
                    rst_done_q <= 1'b1;
                end
            end

            assign in_ready_o = rst_done_q & (~valid_q | out_ready_i);

            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    ctrl_q  <= '0;
                end else if (flush_i) begin
                    valid_q <= 1'b0;
                    ctrl_q  <= '0;
                end else if (push) begin
                    valid_q <= 1'b1;
                    data_q  <= in_data_i;
                    ctrl_q  <= in_ctrl_i;
                end else if (pop) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_valid = valid_q;
            assign held_data = data_q;
            assign held_ctrl = ctrl_q;
            assign occ       = {1'b0, valid_q};
        end else begin : g_skid
            state_t            state_q;
            state_t            state_d;
            logic              ready_q;
            logic              load_main;
            logic              load_skid;
            logic              skid_to_main;
            logic [DATA_W-1:0] main_data_q;
            logic [CTRL_W-1:0] main_ctrl_q;
            logic [DATA_W-1:0] skid_data_q;
            logic [CTRL_W-1:0] skid_ctrl_q;

            // in_ready_o is registered from the next state so that nothing on
            // the output side reaches it combinationally.
            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != ST_TWO);
                end
            end

            always_comb begin
                state_d      = state_q;
                load_main    = 1'b0;
                load_skid    = 1'b0;
                skid_to_main = 1'b0;
                case (state_q)
                    ST_EMPTY: begin
                        if (push) begin
                            load_main = 1'b1;
                            state_d   = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (push && !pop) begin
                            load_skid = 1'b1;
                            state_d   = ST_TWO;
                        end else if (push && pop) begin
                            load_main = 1'b1;
                        end else if (pop) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (pop) begin
                            skid_to_main = 1'b1;
                            state_d      = ST_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                    end
                endcase
                // Flush overrides everything; a same-cycle pop has already
                // been seen downstream, a same-cycle push is dropped.
                if (flush_i) begin
                    state_d      = ST_EMPTY;
                    load_main    = 1'b0;
                    load_skid    = 1'b0;
                    skid_to_main = 1'b0;
                end
            end

            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    main_data_q <= '0;
                    main_ctrl_q <= '0;
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else if (flush_i) begin
                    main_ctrl_q <= '0;
                    skid_ctrl_q <= '0;
                end else begin
                    if (load_main) begin
                        main_data_q <= in_data_i;
                        main_ctrl_q <= in_ctrl_i;
                    end else if (skid_to_main) begin
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                    end
                    if (load_skid) begin
                        skid_data_q <= in_data_i;
                        skid_ctrl_q <= in_ctrl_i;
                    end
                end
            end

            assign in_ready_o = ready_q;
            assign out_valid  = (state_q != ST_EMPTY);
            assign held_data  = main_data_q;
            assign held_ctrl  = main_ctrl_q;
            assign occ        = state_q;
        end
    endgenerate

    // Clear beats a coincident increment; flush leaves the count alone.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_q <= 16'd0;
        end else if (clr_stats_i) begin
            stall_cnt_q <= 16'd0;
        end else if (out_valid && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign out_valid_o = out_valid;
    assign out_data_o  = held_data;
    assign out_ctrl_o  = out_valid ? held_ctrl : '0;
    assign occupancy_o = occ;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg (SKID=1 and SKID=0)

module tb_pipe_stage_reg;

    logic         clk;
    logic         reset_n;

    logic         in_valid, in_ready, flush, out_valid, out_ready, clr_stats;
    logic [127:0] in_data, out_data;
    logic [15:0]  in_ctrl, out_ctrl, stall_cnt;
    logic [1:0]   occ;

    logic         in_valid0, in_ready0, flush0, out_valid0, out_ready0, clr_stats0;
    logic [31:0]  in_data0, out_data0;
    logic [3:0]   in_ctrl0, out_ctrl0;
    logic [15:0]  stall_cnt0;
    logic [1:0]   occ0;

    int n_cmp;
    int n_fail;

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .SKID(1)) u_dut (
        .clk_i(clk), .reset_i(reset_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_ctrl_o(out_ctrl),
        .occupancy_o(occ), .stall_cnt_o(stall_cnt), .clr_stats_i(clr_stats)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(0)) u_dut0 (
        .clk_i(clk), .reset_i(reset_n),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .in_data_i(in_data0), .in_ctrl_i(in_ctrl0), .flush_i(flush0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0),
        .out_data_o(out_data0), .out_ctrl_o(out_ctrl0),
        .occupancy_o(occ0), .stall_cnt_o(stall_cnt0), .clr_stats_i(clr_stats0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, occ, in_ready, out_ctrl, stall_cnt} !== 36'd0 || out_data !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b occ=%0d rdy=%0b ctrl=%0h stall=%0h data=%0h want all 0",
                     out_valid, occ, in_ready, out_ctrl, stall_cnt, out_data);
        end
        n_cmp++;
        if ({out_valid0, occ0, in_ready0} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_s0: got v=%0b occ=%0d rdy=%0b want 0", out_valid0, occ0, in_ready0);
        end
        cycle();
        reset_n = 1'b1;
        n_cmp++;
        if ({in_ready, in_ready0} !== 2'b00) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b want 00", {in_ready, in_ready0});
        end
        cycle();
        n_cmp++;
        if ({in_ready, in_ready0} !== 2'b11) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b want 11", {in_ready, in_ready0});
        end
        // Two items held, then reset mid-cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 128'hA; in_ctrl = 16'h11;
        cycle();
        in_data = 128'hB; in_ctrl = 16'h22;
        cycle();
        in_valid = 1'b0;
        n_cmp++;
        if ({occ, in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL two_held_before_reset: got occ=%0d rdy=%0b want occ=2 rdy=0", occ, in_ready);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, occ, in_ready, out_ctrl, stall_cnt} !== 36'd0 || out_data !== 128'd0) begin
            n_fail++;
            $display("FAIL async_reset_midstream: got v=%0b occ=%0d rdy=%0b ctrl=%0h stall=%0h data=%0h want all 0",
                     out_valid, occ, in_ready, out_ctrl, stall_cnt, out_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        n_cmp++;
        if ({in_ready, occ, out_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL ready_after_midstream_reset: got rdy=%0b occ=%0d v=%0b want rdy=1 occ=0 v=0",
                     in_ready, occ, out_valid);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(i);
            in_ctrl  = 16'(i);
            cycle();
            n_cmp++;
            if ({out_valid, occ, in_ready} !== 4'b1011 || out_data !== 128'(i) || out_ctrl !== 16'(i)) begin
                n_fail++;
                $display("FAIL stream_item_%0d: got v=%0b occ=%0d rdy=%0b data=%0h ctrl=%0h want v=1 occ=1 rdy=1 data=%0h ctrl=%0h",
                         i, out_valid, occ, in_ready, out_data, out_ctrl, i, i);
            end
        end
        in_valid = 1'b0;
        cycle();
        n_cmp++;
        if (occ !== 2'd0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stream_drain: got occ=%0d stall=%0d want occ=0 stall=0", occ, stall_cnt);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 128'hA0; in_ctrl = 16'h0A;
        cycle();
        n_cmp++;
        if ({occ, in_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL bp_after_a: got occ=%0d rdy=%0b want occ=1 rdy=1", occ, in_ready);
        end
        in_data = 128'hB0; in_ctrl = 16'h0B;
        cycle();
        in_data = 128'hC0; in_ctrl = 16'h0C;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({occ, in_ready} !== 3'b100 || out_data !== 128'hA0) begin
                n_fail++;
                $display("FAIL bp_full_%0d: got occ=%0d rdy=%0b data=%0h want occ=2 rdy=0 data=a0",
                         k, occ, in_ready, out_data);
            end
            cycle();
        end
        n_cmp++;
        if (stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_stall_count: got %0d want 3", stall_cnt);
        end
        out_ready = 1'b1;
        cycle();
        n_cmp++;
        if ({occ, in_ready} !== 3'b011 || out_data !== 128'hB0 || out_ctrl !== 16'h0B) begin
            n_fail++;
            $display("FAIL bp_emit_b: got occ=%0d rdy=%0b data=%0h ctrl=%0h want occ=1 rdy=1 data=b0 ctrl=b",
                     occ, in_ready, out_data, out_ctrl);
        end
        cycle();
        in_valid = 1'b0;
        n_cmp++;
        if (occ !== 2'd1 || out_data !== 128'hC0 || out_ctrl !== 16'h0C) begin
            n_fail++;
            $display("FAIL bp_emit_c: got occ=%0d data=%0h ctrl=%0h want occ=1 data=c0 ctrl=c", occ, out_data, out_ctrl);
        end
        cycle();
        n_cmp++;
        if (occ !== 2'd0 || stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_final: got occ=%0d stall=%0d want occ=0 stall=3", occ, stall_cnt);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 128'hD1; in_ctrl = 16'hFFFF;
        cycle();
        in_data = 128'hD2;
        cycle();
        n_cmp++;
        if (occ !== 2'd2 || out_ctrl !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL flush_setup: got occ=%0d ctrl=%0h want occ=2 ctrl=ffff", occ, out_ctrl);
        end
        in_data = 128'hDD; in_ctrl = 16'h1234; flush = 1'b1;
        cycle();
        n_cmp++;
        if ({out_valid, occ, in_ready} !== 4'b0001 || out_ctrl !== 16'h0 || out_data !== 128'hD1) begin
            n_fail++;
            $display("FAIL flush_two: got v=%0b occ=%0d rdy=%0b ctrl=%0h data=%0h want v=0 occ=0 rdy=1 ctrl=0 data=d1",
                     out_valid, occ, in_ready, out_ctrl, out_data);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_ghost: got v=%0b data=%0h want v=0", out_valid, out_data);
        end
        // Flush from ONE with a concurrent push.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 128'hE1; in_ctrl = 16'h00F0;
        cycle();
        n_cmp++;
        if (occ !== 2'd1 || out_ctrl !== 16'h00F0) begin
            n_fail++;
            $display("FAIL flush_one_setup: got occ=%0d ctrl=%0h want occ=1 ctrl=f0", occ, out_ctrl);
        end
        in_data = 128'hE2; in_ctrl = 16'h0F0F; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if ({out_valid, occ, in_ready} !== 4'b0001 || out_ctrl !== 16'h0) begin
            n_fail++;
            $display("FAIL flush_one_push: got v=%0b occ=%0d rdy=%0b ctrl=%0h want v=0 occ=0 rdy=1 ctrl=0",
                     out_valid, occ, in_ready, out_ctrl);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_one_no_ghost: got v=%0b data=%0h want v=0", out_valid, out_data);
        end
        in_valid = 1'b1; in_data = 128'hF0; in_ctrl = 16'h5;
        cycle();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 128'hF0 || out_ctrl !== 16'h5) begin
            n_fail++;
            $display("FAIL flush_recover: got v=%0b data=%0h ctrl=%0h want v=1 data=f0 ctrl=5", out_valid, out_data, out_ctrl);
        end
        cycle();
    endtask

    task automatic test_counter();
        clr_stats = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        cycle();
        clr_stats = 1'b0;
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL cnt_clear_idle: got %0d want 0", stall_cnt);
        end
        in_valid = 1'b1; in_data = 128'hC0; in_ctrl = 16'h1;
        cycle();
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        n_cmp++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_saturate: got %0h want ffff", stall_cnt);
        end
        clr_stats = 1'b1;
        cycle();
        clr_stats = 1'b0;
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL cnt_clear_wins: got %0d want 0", stall_cnt);
        end
        cycle();
        n_cmp++;
        if (stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL cnt_resume: got %0d want 1", stall_cnt);
        end
        out_ready = 1'b1;
        cycle();
        n_cmp++;
        if (occ !== 2'd0 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL cnt_drain: got occ=%0d stall=%0d want occ=0 stall=1", occ, stall_cnt);
        end
    endtask

    task automatic test_single_reg();
        logic [31:0] items [100];
        int          sent;
        int          recv;
        logic        mvalid;
        logic        exp_rdy;
        logic        do_push;
        logic        do_pop;
        for (int i = 0; i < 100; i++) items[i] = $urandom;
        sent = 0; recv = 0; mvalid = 1'b0;
        for (int c = 0; c < 400 && recv < 100; c++) begin
            out_ready0 = (c % 2) == 0;
            in_valid0  = (sent < 100);
            in_data0   = (sent < 100) ? items[sent] : 32'd0;
            in_ctrl0   = in_data0[3:0];
            #1;
            exp_rdy = ~mvalid | out_ready0;
            n_cmp++;
            if (in_ready0 !== exp_rdy || out_valid0 !== mvalid) begin
                n_fail++;
                $display("FAIL s0_ready_c%0d: got rdy=%0b v=%0b want rdy=%0b v=%0b", c, in_ready0, out_valid0, exp_rdy, mvalid);
            end
            if (mvalid) begin
                n_cmp++;
                if (out_data0 !== items[recv] || out_ctrl0 !== items[recv][3:0]) begin
                    n_fail++;
                    $display("FAIL s0_item_%0d: got data=%0h ctrl=%0h want data=%0h ctrl=%0h",
                             recv, out_data0, out_ctrl0, items[recv], items[recv][3:0]);
                end
            end else begin
                n_cmp++;
                if (out_ctrl0 !== 4'd0) begin
                    n_fail++;
                    $display("FAIL s0_bubble_ctrl_c%0d: got %0h want 0", c, out_ctrl0);
                end
            end
            do_pop  = mvalid & out_ready0;
            do_push = in_valid0 & exp_rdy;
            if (do_pop) recv++;
            if (do_push) sent++;
            mvalid = do_push ? 1'b1 : (do_pop ? 1'b0 : mvalid);
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (recv != 100 || sent != 100) begin
            n_fail++;
            $display("FAIL s0_complete: got sent=%0d recv=%0d want 100/100 within budget", sent, recv);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; in_ctrl0 = '0; flush0 = 1'b0; out_ready0 = 1'b0; clr_stats0 = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_counter();
        test_single_reg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
